// File: rtl/uart_fifo.sv
// Full-duplex 8N1 UART with RX/TX FIFOs, programmable baud divisor and sticky error flags.
// Optional irq output and interrupt-enable bits are built when UART_FIFO_IRQ_EN is defined.
module uart_fifo #(
  parameter int unsigned FIFO_AW   = 4,
  parameter int unsigned DIV_RESET = 217,
  parameter int unsigned DIV_W     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] a,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       rnw,
  input  logic       cs,
  input  logic       rxd,
  output logic       txd
`ifdef UART_FIFO_IRQ_EN
  ,
  output logic       irq
`endif
);

  localparam int unsigned DEPTH = 2 ** FIFO_AW;
  localparam int unsigned PW    = FIFO_AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic             cs_q;
  logic             acc_c, wr_c, rd_c;
  logic [DIV_W-1:0] div_q, div_d, div_eff;
  logic             ovr_q, ovr_d, fe_q, fe_d, ovr_set, fe_set;
  logic [1:0]       ie;

  logic [7:0]    tx_mem [DEPTH];
  logic [PW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic          tx_empty, tx_full, tx_push, tx_pop, tx_idle;
  logic [7:0]    tx_head;
  state_e           tx_state_q, tx_state_d;
  logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_sh_q, tx_sh_d;
  logic             txd_q, txd_d;

  logic [7:0]    rx_mem [DEPTH];
  logic [PW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic          rx_empty, rx_full, rx_push, rx_pop;
  logic          rx_s1_q, rx_s2_q, rx_s3_q;
  state_e           rx_state_q, rx_state_d;
  logic [DIV_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_sh_q, rx_sh_d;
  logic [7:0]       status_c;

  assign acc_c   = cs & ~cs_q;
  assign wr_c    = acc_c & ~rnw;
  assign rd_c    = acc_c & rnw;
  assign div_eff = (div_q < DIV_W'(2)) ? DIV_W'(2) : div_q;

  assign tx_empty = (tx_wp_q == tx_rp_q);
  assign tx_full  = (tx_wp_q[PW-1] != tx_rp_q[PW-1]) &&
                    (tx_wp_q[FIFO_AW-1:0] == tx_rp_q[FIFO_AW-1:0]);
  assign rx_empty = (rx_wp_q == rx_rp_q);
  assign rx_full  = (rx_wp_q[PW-1] != rx_rp_q[PW-1]) &&
                    (rx_wp_q[FIFO_AW-1:0] == rx_rp_q[FIFO_AW-1:0]);
  assign tx_head  = tx_mem[tx_rp_q[FIFO_AW-1:0]];
  assign tx_idle  = tx_empty && (tx_state_q == S_IDLE);

  // A shifter pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign tx_push = wr_c && (a == 2'd0) && (!tx_full || tx_pop);
  assign rx_pop  = rd_c && (a == 2'd0) && !rx_empty;
  assign tx_wp_d = tx_wp_q + PW'(tx_push);
  assign tx_rp_d = tx_rp_q + PW'(tx_pop);
  assign rx_wp_d = rx_wp_q + PW'(rx_push);
  assign rx_rp_d = rx_rp_q + PW'(rx_pop);

  assign status_c = {1'b0, ie, tx_idle, fe_q, ovr_q, ~tx_full, ~rx_empty};

  always_comb begin
    dout = 8'h00;
    case (a)
      2'd0:    dout = rx_empty ? 8'h00 : rx_mem[rx_rp_q[FIFO_AW-1:0]];
      2'd1:    dout = status_c;
      2'd2:    dout = div_q[7:0];
      default: dout = 8'(div_q >> 8);
    endcase
  end

  // CPU register writes; a flag set by the receiver wins over a same-cycle clear
  always_comb begin
    div_d = div_q;
    ovr_d = ovr_q;
    fe_d  = fe_q;
    if (wr_c && a == 2'd2) div_d = (div_q & ~DIV_W'(8'hFF)) | DIV_W'(din);
    if (wr_c && a == 2'd3) div_d = (div_q & DIV_W'(8'hFF)) | (DIV_W'(din) << 8);
    if (wr_c && a == 2'd1 && din[2]) ovr_d = 1'b0;
    if (wr_c && a == 2'd1 && din[3]) fe_d  = 1'b0;
    if (ovr_set) ovr_d = 1'b1;
    if (fe_set)  fe_d  = 1'b1;
  end

  // Transmitter: bit period latched at each bit boundary
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    txd_d      = txd_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      S_IDLE: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_sh_d    = tx_head;
          tx_cnt_d   = div_eff - DIV_W'(1);
          tx_state_d = S_START;
          txd_d      = 1'b0;
        end
      end
      S_START: begin
        if (tx_cnt_q == DIV_W'(0)) begin
          tx_cnt_d   = div_eff - DIV_W'(1);
          tx_bit_d   = 3'd0;
          tx_state_d = S_DATA;
          txd_d      = tx_sh_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q - DIV_W'(1);
        end
      end
      S_DATA: begin
        if (tx_cnt_q == DIV_W'(0)) begin
          tx_cnt_d = div_eff - DIV_W'(1);
          if (tx_bit_q == 3'd7) begin
            tx_state_d = S_STOP;
            txd_d      = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            tx_sh_d  = tx_sh_q >> 1;
            txd_d    = tx_sh_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q - DIV_W'(1);
        end
      end
      default: begin
        if (tx_cnt_q == DIV_W'(0)) begin
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_sh_d    = tx_head;
            tx_cnt_d   = div_eff - DIV_W'(1);
            tx_state_d = S_START;
            txd_d      = 1'b0;
          end else begin
            tx_state_d = S_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - DIV_W'(1);
        end
      end
    endcase
  end

  // Receiver: start bit re-checked at half period to reject glitches
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_push    = 1'b0;
    ovr_set    = 1'b0;
    fe_set     = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        if (!rx_s2_q && rx_s3_q) begin
          rx_cnt_d   = (div_eff >> 1) - DIV_W'(1);
          rx_state_d = S_START;
        end
      end
      S_START: begin
        if (rx_cnt_q == DIV_W'(0)) begin
          rx_cnt_d   = div_eff - DIV_W'(1);
          rx_bit_d   = 3'd0;
          rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q - DIV_W'(1);
        end
      end
      S_DATA: begin
        if (rx_cnt_q == DIV_W'(0)) begin
          rx_cnt_d = div_eff - DIV_W'(1);
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q - DIV_W'(1);
        end
      end
      default: begin
        if (rx_cnt_q == DIV_W'(0)) begin
          rx_state_d = S_IDLE;
          if (!rx_s2_q)     fe_set  = 1'b1;
          else if (rx_full) ovr_set = 1'b1;
          else              rx_push = 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q - DIV_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp_q[FIFO_AW-1:0]] <= din;
    if (rx_push) rx_mem[rx_wp_q[FIFO_AW-1:0]] <= rx_sh_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_q       <= 1'b0;
      div_q      <= DIV_W'(DIV_RESET);
      ovr_q      <= 1'b0;
      fe_q       <= 1'b0;
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 3'd0;
      tx_sh_q    <= 8'h00;
      txd_q      <= 1'b1;
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      rx_sh_q    <= 8'h00;
    end else begin
      cs_q       <= cs;
      div_q      <= div_d;
      ovr_q      <= ovr_d;
      fe_q       <= fe_d;
      tx_wp_q    <= tx_wp_d;
      tx_rp_q    <= tx_rp_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      txd_q      <= txd_d;
      rx_wp_q    <= rx_wp_d;
      rx_rp_q    <= rx_rp_d;
      rx_s1_q    <= rxd;
      rx_s2_q    <= rx_s1_q;
      rx_s3_q    <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
    end
  end

  assign txd = txd_q;

`ifdef UART_FIFO_IRQ_EN
  logic [1:0] ie_q, ie_d;
  logic       irq_q, irq_d;

  always_comb begin
    ie_d  = ie_q;
    if (wr_c && a == 2'd1) ie_d = din[6:5];
    irq_d = (ie_q[0] & ~rx_empty) | (ie_q[1] & tx_idle) | (ie_q[0] & (ovr_q | fe_q));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ie_q  <= 2'b00;
      irq_q <= 1'b0;
    end else begin
      ie_q  <= ie_d;
      irq_q <= irq_d;
    end
  end

  assign ie  = ie_q;
  assign irq = irq_q;
`else
  assign ie = 2'b00;
`endif

endmodule

// File: tb/tb_uart_fifo.sv
// Directed self-checking bench for uart_fifo (divisor 8, 4-entry FIFOs).
module tb_uart_fifo;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] a;
  logic [7:0] din, dout;
  logic       rnw, cs, rxd, txd;
`ifdef UART_FIFO_IRQ_EN
  logic       irq;
`endif

  int n_checks = 0;
  int n_errors = 0;

  uart_fifo #(.FIFO_AW(2), .DIV_RESET(8), .DIV_W(16)) dut (
    .clk(clk), .reset(rst_n), .a(a), .din(din), .dout(dout),
    .rnw(rnw), .cs(cs), .rxd(rxd), .txd(txd)
`ifdef UART_FIFO_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cpu_wr(input logic [1:0] addr, input logic [7:0] data);
    @(negedge clk);
    a = addr; din = data; rnw = 1'b0; cs = 1'b1;
    @(negedge clk);
    cs = 1'b0; rnw = 1'b1;
  endtask

  task automatic cpu_rd(input logic [1:0] addr, output logic [7:0] data, input int hold);
    @(negedge clk);
    a = addr; rnw = 1'b1; cs = 1'b1;
    #1 data = dout;
    repeat (hold) @(negedge clk);
    cs = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rxd = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (8) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (8) @(negedge clk);
    rxd = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // Transmits one byte and checks every bit centre plus the return of tx_idle
  task automatic tx_frame_check(input logic [7:0] b);
    logic [9:0] fr;
    int k, idle_k;
    fr = {1'b1, b, 1'b0};
    cpu_wr(2'd0, b);
    a = 2'd1;
    k = 0;
    while (txd !== 1'b0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("tx_start_seen", 32'(txd), 32'd0);
    idle_k = -1;
    for (int s = 1; s <= 100; s++) begin
      @(negedge clk);
      if (s % 8 == 4 && s / 8 < 10) check($sformatf("tx_bit%0d", s / 8), 32'(txd), 32'(fr[s / 8]));
      if (idle_k < 0 && dout[4] === 1'b1) idle_k = s;
    end
    check("tx_idle_latency", 32'(idle_k), 32'd80);
  endtask

  logic [7:0] rd;
  int cnt;

  initial begin
    rst_n = 1'b0; a = 2'd0; din = 8'h00; rnw = 1'b1; cs = 1'b0; rxd = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_txd", 32'(txd), 32'd1);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_txd", 32'(txd), 32'd1);
    end
    cpu_rd(2'd1, rd, 1); check("reset_status", 32'(rd), 32'h12);
    cpu_rd(2'd2, rd, 1); check("reset_div_lo", 32'(rd), 32'h08);
    cpu_rd(2'd3, rd, 1); check("reset_div_hi", 32'(rd), 32'h00);
`ifdef UART_FIFO_IRQ_EN
    check("reset_irq", 32'(irq), 32'd0);
`endif

    cpu_wr(2'd3, 8'hAB);
    cpu_rd(2'd3, rd, 1); check("div_hi_rw", 32'(rd), 32'hAB);
    cpu_wr(2'd3, 8'h00);
    cpu_rd(2'd2, rd, 1); check("div_lo_keep", 32'(rd), 32'h08);

    tx_frame_check(8'hA5);
    tx_frame_check(8'h3E);

    send_rx(8'h3C, 1'b1);
    send_rx(8'h5A, 1'b1);
    cpu_rd(2'd1, rd, 1); check("rx_status_avail", 32'(rd), 32'h13);
    cpu_rd(2'd0, rd, 3); check("rx_first", 32'(rd), 32'h3C);
    cpu_rd(2'd0, rd, 1); check("rx_second_one_pop", 32'(rd), 32'h5A);
    cpu_rd(2'd0, rd, 1); check("rx_empty_read", 32'(rd), 32'h00);
    cpu_rd(2'd1, rd, 1); check("rx_status_empty", 32'(rd), 32'h12);

    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    send_rx(8'h33, 1'b1);
    send_rx(8'h44, 1'b1);
    send_rx(8'h55, 1'b1);
    cpu_rd(2'd1, rd, 1); check("ovr_status", 32'(rd), 32'h17);
    cpu_rd(2'd0, rd, 1); check("ovr_rd0", 32'(rd), 32'h11);
    cpu_rd(2'd0, rd, 1); check("ovr_rd1", 32'(rd), 32'h22);
    cpu_rd(2'd0, rd, 1); check("ovr_rd2", 32'(rd), 32'h33);
    cpu_rd(2'd0, rd, 1); check("ovr_rd3", 32'(rd), 32'h44);
    cpu_rd(2'd1, rd, 1); check("ovr_sticky", 32'(rd), 32'h16);
    cpu_wr(2'd1, 8'h04);
    cpu_rd(2'd1, rd, 1); check("ovr_clear", 32'(rd), 32'h12);

    send_rx(8'h66, 1'b1);
    send_rx(8'h77, 1'b0);
    cpu_rd(2'd1, rd, 1); check("fe_status", 32'(rd), 32'h1B);
    cpu_rd(2'd0, rd, 1); check("fe_fifo_kept", 32'(rd), 32'h66);
    cpu_rd(2'd0, rd, 1); check("fe_discard", 32'(rd), 32'h00);
    cpu_wr(2'd1, 8'h08);
    cpu_rd(2'd1, rd, 1); check("fe_clear", 32'(rd), 32'h12);
    @(negedge clk); rxd = 1'b0;
    repeat (2) @(negedge clk); rxd = 1'b1;
    repeat (120) @(negedge clk);
    cpu_rd(2'd1, rd, 1); check("glitch_status", 32'(rd), 32'h12);

    cpu_wr(2'd0, 8'h81);
    cpu_wr(2'd0, 8'h42);
    cpu_wr(2'd0, 8'h24);
    repeat (85) @(negedge clk);
    cnt = 0;
    while (txd !== 1'b0 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("mid_frame_low", 32'(txd), 32'd0);
    rst_n = 1'b0;
    #1 check("abort_txd", 32'(txd), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    cpu_rd(2'd1, rd, 1); check("abort_status", 32'(rd), 32'h12);
    repeat (30) @(negedge clk);
    check("abort_quiet", 32'(txd), 32'd1);

`ifdef UART_FIFO_IRQ_EN
    cpu_wr(2'd1, 8'h20);
    cpu_rd(2'd1, rd, 1); check("ie_status", 32'(rd), 32'h32);
    check("irq_low", 32'(irq), 32'd0);
    a = 2'd1;
    fork
      send_rx(8'h9C, 1'b1);
      begin
        cnt = 0;
        while (dout[0] !== 1'b1 && cnt < 200) begin
          @(negedge clk);
          cnt++;
        end
        check("irq_push_seen", 32'(dout[0]), 32'd1);
        check("irq_not_yet", 32'(irq), 32'd0);
        @(negedge clk);
        check("irq_next_cycle", 32'(irq), 32'd1);
      end
    join
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
